// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: 640x480@60 Hz raster timing, game-cell coordinate source,
// and registered DAC output stage (pixel, syncs, blanking, frame tick).
// Optional feature: define VGA_BORDER_EN to force a white one-cell border.
module vga_scan_ctrl #(
    parameter int unsigned H_VIS  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_VIS  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [6:0]  o_game_x,
    output logic [6:0]  o_game_y,
    output logic [3:0]  o_grid_x,
    output logic [3:0]  o_grid_y,
    input  logic [23:0] i_rgb,
    output logic [23:0] o_rgb,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_blank_n,
    output logic        o_frame_tick
);
    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW    = $clog2(H_TOT);
    localparam int unsigned VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_VIS_C = HW'(H_VIS);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_VIS_C = VW'(V_VIS);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [3:0]    PIX_LAST = 4'd9;

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          line_end;

    // free-running cell/pixel counters; gated to zero into the output registers
    logic [6:0] cx_q, cx_d, cy_q, cy_d;
    logic [3:0] px_q, px_d, py_q, py_d;

    logic [6:0] game_x_q, game_x_d, game_y_q, game_y_d;
    logic [3:0] grid_x_q, grid_x_d, grid_y_q, grid_y_d;
    logic       vis_d;

    logic        vis_s0;
    logic [23:0] rgb_q, rgb_d;
    logic        hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d, tick_q, tick_d;

    // Stage 0: raster counters and parallel cell/pixel coordinate counters
    always_comb begin
        line_end = (h_q == H_LAST);
        h_d      = line_end ? '0 : h_q + 1'b1;
        v_d      = v_q;
        if (line_end) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end

        cx_d = cx_q;
        px_d = px_q;
        if (h_d == '0) begin
            cx_d = '0;
            px_d = '0;
        end else if (h_d < H_VIS_C) begin
            if (px_q == PIX_LAST) begin
                px_d = '0;
                cx_d = cx_q + 7'd1;
            end else begin
                px_d = px_q + 4'd1;
            end
        end

        cy_d = cy_q;
        py_d = py_q;
        if (line_end) begin
            if (v_d == '0) begin
                cy_d = '0;
                py_d = '0;
            end else if (v_d < V_VIS_C) begin
                if (py_q == PIX_LAST) begin
                    py_d = '0;
                    cy_d = cy_q + 7'd1;
                end else begin
                    py_d = py_q + 4'd1;
                end
            end
        end

        vis_d    = (h_d < H_VIS_C) && (v_d < V_VIS_C);
        game_x_d = vis_d ? cx_d : '0;
        grid_x_d = vis_d ? px_d : '0;
        game_y_d = vis_d ? cy_d : '0;
        grid_y_d = vis_d ? py_d : '0;
    end

    // Stage 1: DAC outputs decoded from the stage-0 registers
    always_comb begin
        vis_s0 = (h_q < H_VIS_C) && (v_q < V_VIS_C);
        rgb_d  = vis_s0 ? i_rgb : '0;
`ifdef VGA_BORDER_EN
        if (vis_s0 && ((game_x_q == 7'd0) || (game_x_q == 7'd63) ||
                       (game_y_q == 7'd0) || (game_y_q == 7'd47))) begin
            rgb_d = 24'hFFFFFF;
        end
`endif
        blank_n_d = vis_s0;
        hs_d      = !((h_q >= HS_BEG) && (h_q <= HS_END));
        vs_d      = !((v_q >= VS_BEG) && (v_q <= VS_END));
        tick_d    = (h_q == '0) && (v_q == V_VIS_C);
    end

    // Register both stages
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_q       <= '0;
            v_q       <= '0;
            cx_q      <= '0;
            px_q      <= '0;
            cy_q      <= '0;
            py_q      <= '0;
            game_x_q  <= '0;
            grid_x_q  <= '0;
            game_y_q  <= '0;
            grid_y_q  <= '0;
            rgb_q     <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            cx_q      <= cx_d;
            px_q      <= px_d;
            cy_q      <= cy_d;
            py_q      <= py_d;
            game_x_q  <= game_x_d;
            grid_x_q  <= grid_x_d;
            game_y_q  <= game_y_d;
            grid_y_q  <= grid_y_d;
            rgb_q     <= rgb_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            tick_q    <= tick_d;
        end
    end

    assign o_game_x     = game_x_q;
    assign o_grid_x     = grid_x_q;
    assign o_game_y     = game_y_q;
    assign o_grid_y     = grid_y_q;
    assign o_rgb        = rgb_q;
    assign o_hs         = hs_q;
    assign o_vs         = vs_q;
    assign o_blank_n    = blank_n_q;
    assign o_frame_tick = tick_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: full-timing instance (a_*) for line/coordinate
// checks, short-frame instance (b_*) for frame period and mid-line reset.
module tb_vga_scan_ctrl;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    localparam int A_VVIS = 480, A_VFP = 10, A_VSYNC = 2, A_VTOT = 525;
    localparam int B_VVIS = 12,  B_VFP = 2,  B_VSYNC = 2, B_VTOT = 18;
    localparam logic [27:0] RST_S1 = {24'h0, 1'b0, 1'b1, 1'b1, 1'b0};

    int n_tests = 0;
    int n_fail  = 0;

    logic        rst_a_n, rst_b_n;
    logic [6:0]  a_gx, a_gy, b_gx, b_gy;
    logic [3:0]  a_grx, a_gry, b_grx, b_gry;
    logic [23:0] a_rgb_i, a_rgb, b_rgb_i, b_rgb;
    logic        a_hs, a_vs, a_blank, a_tick, b_hs, b_vs, b_blank, b_tick;

    // combinational ROM-mux stand-in driven from the presented coordinates
    assign a_rgb_i = {a_gx, a_grx, a_gy, a_gry, 2'b00};
    assign b_rgb_i = {b_gx, b_grx, b_gy, b_gry, 2'b00};

    vga_scan_ctrl dut_a (
        .i_clk(clk), .i_rst_n(rst_a_n),
        .o_game_x(a_gx), .o_game_y(a_gy), .o_grid_x(a_grx), .o_grid_y(a_gry),
        .i_rgb(a_rgb_i), .o_rgb(a_rgb), .o_hs(a_hs), .o_vs(a_vs),
        .o_blank_n(a_blank), .o_frame_tick(a_tick)
    );

    vga_scan_ctrl #(.V_VIS(B_VVIS), .V_FP(B_VFP), .V_SYNC(B_VSYNC), .V_BP(2)) dut_b (
        .i_clk(clk), .i_rst_n(rst_b_n),
        .o_game_x(b_gx), .o_game_y(b_gy), .o_grid_x(b_grx), .o_grid_y(b_gry),
        .i_rgb(b_rgb_i), .o_rgb(b_rgb), .o_hs(b_hs), .o_vs(b_vs),
        .o_blank_n(b_blank), .o_frame_tick(b_tick)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [21:0] exp_coord(input int h, input int v, input int vvis);
        if (h < 640 && v < vvis) return {7'(h / 10), 4'(h % 10), 7'(v / 10), 4'(v % 10)};
        return 22'h0;
    endfunction

    function automatic logic [27:0] exp_s1(input int h, input int v, input int vvis,
                                           input int vfp, input int vsync);
        logic        vis;
        logic [21:0] c;
        logic [23:0] rgb;
        vis = (h < 640) && (v < vvis);
        c   = exp_coord(h, v, vvis);
        rgb = vis ? {c, 2'b00} : 24'h0;
`ifdef VGA_BORDER_EN
        if (vis && (c[21:15] == 7'd0 || c[21:15] == 7'd63 || c[10:4] == 7'd0 || c[10:4] == 7'd47))
            rgb = 24'hFFFFFF;
`endif
        return {rgb, vis, !(h >= 656 && h <= 751),
                !(v >= vvis + vfp && v <= vvis + vfp + vsync - 1), (h == 0 && v == vvis)};
    endfunction

    // reference raster positions
    int mh_a, mv_a, mh_b, mv_b;
    always @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            mh_a <= 0; mv_a <= 0;
        end else if (mh_a == 799) begin
            mh_a <= 0; mv_a <= (mv_a == A_VTOT - 1) ? 0 : mv_a + 1;
        end else mh_a <= mh_a + 1;
    end
    always @(posedge clk or negedge rst_b_n) begin
        if (!rst_b_n) begin
            mh_b <= 0; mv_b <= 0;
        end else if (mh_b == 799) begin
            mh_b <= 0; mv_b <= (mv_b == B_VTOT - 1) ? 0 : mv_b + 1;
        end else mh_b <= mh_b + 1;
    end

    // scoreboards: expectation pushed at stimulus time, popped one cycle later
    logic [27:0] sb_a[$];
    logic [27:0] sb_b[$];
    initial begin
        logic [27:0] e;
        forever begin
            @(negedge clk);
            if (!rst_a_n) begin
                sb_a.delete();
                chk("a_rst_out", 32'({a_rgb, a_blank, a_hs, a_vs, a_tick}), 32'(RST_S1));
                chk("a_rst_coord", 32'({a_gx, a_grx, a_gy, a_gry}), 32'h0);
            end else begin
                e = (sb_a.size() > 0) ? sb_a.pop_front() : RST_S1;
                chk("a_out", 32'({a_rgb, a_blank, a_hs, a_vs, a_tick}), 32'(e));
                chk("a_coord", 32'({a_gx, a_grx, a_gy, a_gry}), 32'(exp_coord(mh_a, mv_a, A_VVIS)));
                sb_a.push_back(exp_s1(mh_a, mv_a, A_VVIS, A_VFP, A_VSYNC));
            end
        end
    end
    initial begin
        logic [27:0] e;
        forever begin
            @(negedge clk);
            if (!rst_b_n) begin
                sb_b.delete();
                chk("b_rst_out", 32'({b_rgb, b_blank, b_hs, b_vs, b_tick}), 32'(RST_S1));
                chk("b_rst_coord", 32'({b_gx, b_grx, b_gy, b_gry}), 32'h0);
            end else begin
                e = (sb_b.size() > 0) ? sb_b.pop_front() : RST_S1;
                chk("b_out", 32'({b_rgb, b_blank, b_hs, b_vs, b_tick}), 32'(e));
                chk("b_coord", 32'({b_gx, b_grx, b_gy, b_gry}), 32'(exp_coord(mh_b, mv_b, B_VVIS)));
                sb_b.push_back(exp_s1(mh_b, mv_b, B_VVIS, B_VFP, B_VSYNC));
            end
        end
    end

    typedef struct {
        int         h;
        int         v;
        logic [6:0] gx;
        logic [3:0] grx;
        logic [6:0] gy;
        logic [3:0] gry;
        logic       blank;
        logic       hs;
    } vec_t;
    vec_t vecs[13];

    initial begin
        #(3000000);
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{5,   1,  7'd0,  4'd5, 7'd0, 4'd1, 1'b1, 1'b1};
        vecs[1]  = '{9,   2,  7'd0,  4'd9, 7'd0, 4'd2, 1'b1, 1'b1};
        vecs[2]  = '{10,  2,  7'd1,  4'd0, 7'd0, 4'd2, 1'b1, 1'b1};
        vecs[3]  = '{127, 35, 7'd12, 4'd7, 7'd3, 4'd5, 1'b1, 1'b1};
        vecs[4]  = '{639, 35, 7'd63, 4'd9, 7'd3, 4'd5, 1'b1, 1'b1};
        vecs[5]  = '{640, 35, 7'd0,  4'd0, 7'd0, 4'd0, 1'b0, 1'b1};
        vecs[6]  = '{656, 35, 7'd0,  4'd0, 7'd0, 4'd0, 1'b0, 1'b0};
        vecs[7]  = '{751, 35, 7'd0,  4'd0, 7'd0, 4'd0, 1'b0, 1'b0};
        vecs[8]  = '{752, 35, 7'd0,  4'd0, 7'd0, 4'd0, 1'b0, 1'b1};
        vecs[9]  = '{799, 35, 7'd0,  4'd0, 7'd0, 4'd0, 1'b0, 1'b1};
        vecs[10] = '{0,   36, 7'd0,  4'd0, 7'd3, 4'd6, 1'b1, 1'b1};
        vecs[11] = '{3,   39, 7'd0,  4'd3, 7'd3, 4'd9, 1'b1, 1'b1};
        vecs[12] = '{0,   40, 7'd0,  4'd0, 7'd4, 4'd0, 1'b1, 1'b1};

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_coord", 32'({a_gx, a_grx, a_gy, a_gry}), 32'h0);
        chk("reset_hs_vs", 32'({a_hs, a_vs}), 32'h3);
        chk("reset_blank_tick_rgb", 32'({a_blank, a_tick, a_rgb}), 32'h0);

        fork
            begin : seq_a
                int  n, len;
                bit  found, ok;
                @(posedge clk);
                #2 rst_a_n = 1'b1;
                #1 chk("rel_cycle0_blank", 32'(a_blank), 32'h0);
                @(posedge clk);
                #1 n = 1;
                chk("rel_cycle1_blank", 32'(a_blank), 32'h1);
                found = 1'b0;
                for (int i = 0; i < 2000; i++) begin
                    if (!a_hs) begin
                        found = 1'b1;
                        break;
                    end
                    @(posedge clk);
                    #1 n++;
                end
                chk("hs_first_fall_found", 32'(found), 32'h1);
                chk("hs_first_fall_cycle", 32'(n), 32'd657);
                len = 1;
                for (int i = 0; i < 200; i++) begin
                    @(posedge clk);
                    #1;
                    if (a_hs) break;
                    len++;
                end
                chk("hs_low_len", 32'(len), 32'd96);

                @(negedge clk);
                for (int i = 0; i < 13; i++) begin
                    ok = 1'b0;
                    for (int c = 0; c < 40000; c++) begin
                        if (mh_a == vecs[i].h && mv_a == vecs[i].v) begin
                            ok = 1'b1;
                            break;
                        end
                        @(negedge clk);
                    end
                    chk("vec_reached", 32'(ok), 32'h1);
                    chk("vec_coord", 32'({a_gx, a_grx, a_gy, a_gry}),
                        32'({vecs[i].gx, vecs[i].grx, vecs[i].gy, vecs[i].gry}));
                    @(negedge clk);
                    chk("vec_blank_hs", 32'({a_blank, a_hs}), 32'({vecs[i].blank, vecs[i].hs}));
                end
            end
            begin : seq_b
                int n, ticks, vs_fall, vs_len;
                int t[3];
                bit vs_done, ok;
                @(posedge clk);
                #2 rst_b_n = 1'b1;
                n = 0; ticks = 0; vs_fall = 0; vs_len = 0; vs_done = 1'b0;
                t[0] = 0; t[1] = 0; t[2] = 0;
                for (int i = 0; i < 60000 && ticks < 3; i++) begin
                    @(posedge clk);
                    #1 n++;
                    if (b_tick) begin
                        t[ticks] = n;
                        ticks++;
                    end
                    if (!b_vs) begin
                        if (vs_fall == 0) vs_fall = n;
                        if (!vs_done) vs_len++;
                    end else if (vs_fall != 0) vs_done = 1'b1;
                end
                chk("tick_count", 32'(ticks), 32'd3);
                chk("tick_first", 32'(t[0]), 32'd9601);
                chk("tick_period1", 32'(t[1] - t[0]), 32'd14400);
                chk("tick_period2", 32'(t[2] - t[1]), 32'd14400);
                chk("vs_first_fall", 32'(vs_fall), 32'd11201);
                chk("vs_low_len", 32'(vs_len), 32'd1600);

                ok = 1'b0;
                for (int c = 0; c < 20000; c++) begin
                    @(negedge clk);
                    if (mh_b == 300 && mv_b == 5) begin
                        ok = 1'b1;
                        break;
                    end
                end
                chk("midreset_reached", 32'(ok), 32'h1);
                chk("midreset_pre_blank", 32'(b_blank), 32'h1);
                #2 rst_b_n = 1'b0;
                #1;
                chk("midreset_async_coord", 32'({b_gx, b_grx, b_gy, b_gry}), 32'h0);
                chk("midreset_async_out", 32'({b_rgb, b_blank, b_hs, b_vs, b_tick}), 32'(RST_S1));
                repeat (5) @(posedge clk);
                #2 rst_b_n = 1'b1;
                #1 chk("restart_cycle0", 32'({b_blank, b_gx, b_grx, b_gy, b_gry}), 32'h0);
                @(posedge clk);
                #1;
                chk("restart_cycle1_blank", 32'(b_blank), 32'h1);
                chk("restart_cycle1_coord", 32'({b_gx, b_grx, b_gy, b_gry}), 32'({7'd0, 4'd1, 7'd0, 4'd0}));
                repeat (900) @(posedge clk);
            end
        join

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_scan_ctrl.md
# vga_scan_ctrl

- Drives the 640x480@60 Hz VGA raster and is the source of the game/grid coordinates that every display ROM in the design consumes.
- Each cycle it presents the current pixel position as a game cell (64x48 cells) plus an intra-cell offset (10x10 pixels).
- It samples the 24-bit RGB that the display-ROM mux returns combinationally and registers it.
- It emits aligned pixel, sync and blanking signals to the DAC, plus a per-frame tick for game-state updates.

## Interface
Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch

Ports:
- i_clk  input  1  pixel clock, 25 MHz; all logic is rising-edge
- i_rst_n  input  1  asynchronous active-low reset
- o_game_x  output  7  game cell column, 0..63
- o_game_y  output  7  game cell row, 0..47
- o_grid_x  output  4  pixel column within the cell, 0..9
- o_grid_y  output  4  pixel row within the cell, 0..9
- i_rgb  input  24  pixel colour for the current coordinates, combinational from the ROM mux
- o_rgb  output  24  registered pixel to DAC, {R,G,B} 8 bits each
- o_hs  output  1  horizontal sync, active-low
- o_vs  output  1  vertical sync, active-low
- o_blank_n  output  1  high during the visible area
- o_frame_tick  output  1  one-cycle pulse at the start of vertical blank

## Operation
- **Stage 0 counters:**
  - h_cnt runs 0..799 and v_cnt runs 0..524. Totals are H_VIS+H_FP+H_SYNC+H_BP and V_VIS+V_FP+V_SYNC+V_BP.
  - h_cnt wraps 799->0 and increments v_cnt in the same cycle. v_cnt wraps 524->0.
- **Coordinate counters:**
  - game_x/grid_x and game_y/grid_y are parallel registered counters; no dividers or multipliers are used.
  - grid_x increments with h_cnt and wraps 9->0, incrementing game_x.
  - When h_cnt wraps, game_x and grid_x clear.
  - grid_y/game_y behave the same on each line wrap. Both clear when v_cnt wraps.
- **Coordinates in blanking:** when h_cnt >= H_VIS or v_cnt >= V_VIS, o_game_*/o_grid_* hold 0. The invariant is game_x*10+grid_x == h_cnt whenever h_cnt < H_VIS (same for y).
- **Visibility:** a stage-0 position is visible when h_cnt < H_VIS and v_cnt < V_VIS.
- **Stage 1 registers, from the stage-0 decode:**
  - o_rgb <= visible ? i_rgb : 0
  - o_blank_n <= visible
  - o_hs <= !(h_cnt in [656,751])
  - o_vs <= !(v_cnt in [490,491])
- **Frame tick:** o_frame_tick <= (h_cnt==0 && v_cnt==V_VIS). This is exactly one pulse per frame, and game logic may update sprite state during the vertical blank that follows.
- **Reset values:** h_cnt, v_cnt and all coordinate outputs are 0; o_rgb=0, o_hs=1, o_vs=1, o_blank_n=0, o_frame_tick=0.
- **Reset mid-operation:** reset asserted at any point returns everything to the reset values immediately. Scanning restarts at (0,0) on the first clock edge after deassertion.

## Timing
- Coordinates change on the clock edge; i_rgb must settle within the same cycle.
- Latency from coordinates to o_rgb is exactly 1 cycle. o_hs, o_vs, o_blank_n and o_frame_tick carry the same 1-cycle delay, so all DAC outputs stay mutually aligned.
- Periods:
  - Line: 800 cycles.
  - Frame: 420000 cycles.
  - o_hs low: 96 cycles per line.
  - o_vs low: 1600 cycles per frame.
- First visible pixel after reset: coordinates (0,0) in cycle 0 after deassertion; o_blank_n=1 and o_rgb=i_rgb(0,0) in cycle 1.
- Stage 1 uses only stage-0 registers and i_rgb; no other combinational path feeds the outputs.

## Configuration
- VGA_BORDER_EN defined:
  - o_rgb is forced to 24'hFFFFFF in the visible cells with game_x==0, game_x==63, game_y==0 or game_y==47, regardless of i_rgb.
  - The border is registered in stage 1 with the same 1-cycle latency.
- Not defined: o_rgb is the plain visible-gated i_rgb, and no border logic is synthesized.

## Test plan
- **Reset release:** hold i_rst_n low, then release. Required: coordinates (0,0,0,0) and o_hs=o_vs=1 while in reset; o_blank_n rises on cycle 1; o_hs first falls 657 cycles after release and stays low 96 cycles.
- **Coordinate decode:** at h_cnt=127, v_cnt=35 -> o_game_x=12, o_grid_x=7, o_game_y=3, o_grid_y=5. At h_cnt=640 -> all coordinates 0 and o_blank_n=0 one cycle later.
- **RGB passthrough:** model i_rgb={game_x,grid_x,game_y,grid_y,2'b0} -> o_rgb equals the previous cycle's value in the visible area and 0 in blanking.
- **Frame periods:** run 3 frames -> exactly 3 o_frame_tick pulses 420000 cycles apart; o_vs low for 1600 cycles, starting 490*800 cycles after the frame start.
- **Mid-line reset:** assert i_rst_n low at h_cnt=300, v_cnt=200 for 5 cycles -> outputs take reset values asynchronously; scan restarts at (0,0).
- **Border (VGA_BORDER_EN):** drive i_rgb=24'h000000 -> o_rgb=24'hFFFFFF on pixels 0..9 and 630..639 of every line and on lines 0..9 and 470..479, and 0 elsewhere.
